// File: rtl/int_ctrl.sv
// Six-source programmable interrupt controller feeding CP0 HWInt: per-source
// mask and edge/level mode, fixed priority with in-service nesting and EOI.
module int_ctrl #(
  parameter int          N_SRC     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             int_ack,
  output logic [N_SRC-1:0] hwint
);

  typedef enum logic [1:0] {
    REG_PEND  = 2'd0,
    REG_MASK  = 2'd1,
    REG_MODE  = 2'd2,
    REG_INSVC = 2'd3
  } reg_sel_e;

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  // Isolates the lowest set bit (highest priority); zero stays zero.
  function automatic logic [N_SRC-1:0] lowest_set(input logic [N_SRC-1:0] v);
    return v & (~v + ONE);
  endfunction

  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] insvc;
  logic [N_SRC-1:0] irq_q;

  // MMIO decode: a hit is a word-aligned byte address inside the 16-byte window.
  logic [31:0] offset;
  logic        hit;
  reg_sel_e    sel;

  assign offset = addr - BASE_ADDR;
  assign hit    = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00);
  assign sel    = reg_sel_e'(offset[3:2]);

  logic [N_SRC-1:0] wbits;
  logic             unused_wdata_hi;

  assign wbits           = wdata[N_SRC-1:0];
  assign unused_wdata_hi = |wdata[31:N_SRC];

  logic             pend_we;
  logic             mask_we;
  logic             mode_we;
  logic             eoi;

  assign pend_we = we && hit && (sel == REG_PEND);
  assign mask_we = we && hit && (sel == REG_MASK);
  assign mode_we = we && hit && (sel == REG_MODE);
  assign eoi     = we && hit && (sel == REG_INSVC);

  // Priority and nesting: only sources strictly above the top in-service one
  // may request, and only the single highest of those is presented.
  logic [N_SRC-1:0] top_isv;
  logic [N_SRC-1:0] allowed;
  logic [N_SRC-1:0] eligible;

  assign top_isv  = lowest_set(insvc);
  assign allowed  = (insvc == '0) ? '1 : (top_isv - ONE);
  assign eligible = pend & mask & allowed;
  assign hwint    = lowest_set(eligible);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack_vec;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] eoi_clr;
  logic [N_SRC-1:0] to_edge;
  logic [N_SRC-1:0] edge_next;
  logic [N_SRC-1:0] pend_next;
  logic [N_SRC-1:0] insvc_next;

  assign rise    = irq_in & ~irq_q;
  assign ack_vec = int_ack ? hwint : '0;
  assign w1c     = pend_we ? wbits : '0;
  assign eoi_clr = eoi ? top_isv : '0;
  assign to_edge = mode_we ? (wbits & ~mode) : '0;

  // A rising edge re-pends even when W1C or an ack clears the same bit.
  assign edge_next  = (pend & ~w1c & ~ack_vec) | rise;
  assign pend_next  = ((mode & edge_next) | (~mode & irq_in)) & ~to_edge;
  // EOI retires the old top first, so a same-cycle ack still lands.
  assign insvc_next = (insvc & ~eoi_clr) | ack_vec;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset) begin
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      insvc <= '0;
      irq_q <= '0;
    end else begin
      irq_q <= irq_in;
      pend  <= pend_next;
      insvc <= insvc_next;
      if (mask_we) mask <= wbits;
      if (mode_we) mode <= wbits;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves rdata unassigned,
    // which would otherwise infer a latch.
    rdata = '0;
    if (hit) begin
      unique case (sel)
        REG_PEND:  rdata[N_SRC-1:0] = pend;
        REG_MASK:  rdata[N_SRC-1:0] = mask;
        REG_MODE:  rdata[N_SRC-1:0] = mode;
        REG_INSVC: rdata[N_SRC-1:0] = insvc;
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, edge/level pending, W1C, nesting with EOI
// and the same-cycle set-wins / EOI-then-ack cases.
module tb_int_ctrl;

  localparam int          N_SRC = 6;
  localparam logic [31:0] BASE  = 32'h0000_7F30;
  localparam logic [31:0] A_PEND  = BASE + 32'h0;
  localparam logic [31:0] A_MASK  = BASE + 32'h4;
  localparam logic [31:0] A_MODE  = BASE + 32'h8;
  localparam logic [31:0] A_INSVC = BASE + 32'hC;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SRC-1:0] irq_in;
  logic             we;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             int_ack;
  logic [N_SRC-1:0] hwint;

  int n_checks = 0;
  int n_errors = 0;

  int_ctrl #(.N_SRC(N_SRC), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .int_ack (int_ack),
    .hwint   (hwint)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_hw(input string tag, input logic [N_SRC-1:0] exp);
    check(tag, 32'(hwint), 32'(exp));
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0; wdata = '0;
  endtask

  task automatic pulse_irq(input logic [N_SRC-1:0] v);
    irq_in = v;
    step();
    irq_in = '0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  initial begin
    // Reset with all sources high and a MASK write that must be ignored.
    reset = 1'b0; irq_in = 6'h3F; we = 1'b1; addr = A_MASK; wdata = 32'h3F; int_ack = 1'b0;
    step(); step();
    we = 1'b0;
    check_hw("reset_hwint", 6'h00);
    check_reg("reset_pend", A_PEND, 32'h0);
    check_reg("reset_mask", A_MASK, 32'h0);
    check_reg("reset_mode", A_MODE, 32'h0);
    check_reg("reset_insvc", A_INSVC, 32'h0);
    reset = 1'b1;
    step(); step();
    check_hw("post_reset_masked", 6'h00);
    check_reg("post_reset_level_pend", A_PEND, 32'h3F);
    check_reg("unmapped_read", BASE + 32'h10, 32'h0);
    check_reg("unaligned_read", BASE + 32'h1, 32'h0);

    // Edge mode: one-cycle pulse on source 3 latches until W1C.
    irq_in = '0;
    mmio_write(A_MODE, 32'h3F);
    mmio_write(A_MASK, 32'hFFFF_FFFF);
    check_reg("mask_upper_bits_zero", A_MASK, 32'h3F);
    check_reg("mode_to_edge_clears_pend", A_PEND, 32'h0);
    pulse_irq(6'h08);
    check_hw("edge_hwint", 6'h08);
    check_reg("edge_pend", A_PEND, 32'h08);
    step();
    check_hw("edge_hwint_holds", 6'h08);
    mmio_write(A_PEND, 32'h08);
    check_reg("w1c_pend", A_PEND, 32'h0);
    check_hw("w1c_hwint", 6'h00);

    // Level mode: priority, ack blocks lower source, EOI releases.
    mmio_write(A_MODE, 32'h0);
    irq_in = 6'h24;
    step();
    check_hw("level_priority", 6'h04);
    ack();
    check_reg("level_ack_insvc", A_INSVC, 32'h04);
    check_hw("level_bit5_blocked", 6'h00);
    mmio_write(A_INSVC, 32'h0);
    check_reg("level_eoi_insvc", A_INSVC, 32'h0);
    check_hw("level_after_eoi", 6'h04);
    irq_in = '0;
    step();
    check_reg("level_pend_follows", A_PEND, 32'h0);

    // Nesting: source 4 in service, higher-priority source 1 preempts.
    mmio_write(A_MODE, 32'h3F);
    pulse_irq(6'h10);
    check_hw("nest_src4_req", 6'h10);
    ack();
    check_reg("nest_insvc_10", A_INSVC, 32'h10);
    check_reg("nest_ack_clears_edge", A_PEND, 32'h0);
    pulse_irq(6'h02);
    check_hw("nest_src1_req", 6'h02);
    ack();
    check_reg("nest_insvc_12", A_INSVC, 32'h12);
    mmio_write(A_INSVC, 32'h0);
    check_reg("nest_eoi1", A_INSVC, 32'h10);
    mmio_write(A_INSVC, 32'h0);
    check_reg("nest_eoi2", A_INSVC, 32'h0);
    mmio_write(A_INSVC, 32'h0);
    check_reg("eoi_empty_noop", A_INSVC, 32'h0);

    // Rising edge beats W1C on the same bit.
    irq_in = 6'h04; we = 1'b1; addr = A_PEND; wdata = 32'h04;
    step();
    we = 1'b0;
    check_reg("edge_beats_w1c", A_PEND, 32'h04);
    check_hw("edge_beats_w1c_hw", 6'h04);
    irq_in = '0;
    step();
    // Rising edge beats the ack clear: in service and re-pended.
    irq_in = 6'h04;
    ack();
    check_reg("edge_beats_ack_insvc", A_INSVC, 32'h04);
    check_reg("edge_beats_ack_pend", A_PEND, 32'h04);
    check_hw("self_blocked", 6'h00);
    mmio_write(A_INSVC, 32'h0);
    mmio_write(A_PEND, 32'h04);
    irq_in = '0;
    check_reg("cleanup_pend", A_PEND, 32'h0);

    // EOI and ack in the same cycle: old top retired, new one accepted.
    pulse_irq(6'h08);
    ack();
    check_reg("eoi_ack_setup", A_INSVC, 32'h08);
    pulse_irq(6'h01);
    check_hw("eoi_ack_req", 6'h01);
    we = 1'b1; addr = A_INSVC; wdata = 32'h0; int_ack = 1'b1;
    step();
    we = 1'b0; int_ack = 1'b0;
    check_reg("eoi_then_ack", A_INSVC, 32'h01);
    check_hw("eoi_then_ack_hw", 6'h00);

    // MASK write and ack together: ack uses the pre-write request.
    pulse_irq(6'h20);
    check_hw("mask_ack_pre_req", 6'h00);
    mmio_write(A_INSVC, 32'h0);
    check_hw("mask_ack_req", 6'h20);
    we = 1'b1; addr = A_MASK; wdata = 32'h0; int_ack = 1'b1;
    step();
    we = 1'b0; int_ack = 1'b0;
    check_reg("mask_ack_insvc", A_INSVC, 32'h20);

    // Reset mid-nesting drops everything.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_reg("midreset_insvc", A_INSVC, 32'h0);
    check_reg("midreset_mode", A_MODE, 32'h0);
    check_hw("midreset_hwint", 6'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
